// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Byte-stream program loader: the writer side of the processor's instruction
// memory. Accepts a frame of {LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, CSUM},
// writes each 16-bit word to consecutive addresses starting at 0, and keeps
// the processor held in reset until a frame with a good XOR checksum lands.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-low reset
//   in_data/in_valid     incoming stream byte and its qualifier
//   in_ready             loader can take a byte this cycle
//   start                one-cycle pulse, re-arms the loader from DONE/ERR
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   cpu_hold             1 = keep the processor in reset
//   done                 sticky: load finished with good checksum
//   error                sticky: checksum mismatch or length overflow
//   words_loaded         number of words written in the current frame
//   current_state_output FSM state for monitoring
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        current_state_output
);

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    // Largest legal word count, widened so that 2^ADDR_W itself is representable.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t              state_reg;
    logic [15:0]         len_reg;
    logic [7:0]          hi_reg;
    logic [7:0]          csum_reg;
    logic [ADDR_W:0]     wl_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic                we_reg;
    logic                hold_reg;
    logic                done_reg;
    logic                err_reg;

    logic                ready_int;
    logic                accept;
    logic [16:0]         len_full;
    logic [16:0]         wl_next_full;

    // No byte is taken during the write-strobe cycle so each word gets its
    // own single-cycle mem_we pulse.
    assign ready_int = !we_reg && (state_reg inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                                     S_DATA_LO, S_CSUM});
    assign accept    = in_valid && ready_int;

    // Length as it will be once the low byte currently on the bus is taken.
    assign len_full     = {1'b0, len_reg[15:8], in_data};
    assign wl_next_full = 17'(wl_reg) + 17'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_LEN_HI;
            len_reg   <= '0;
            hi_reg    <= '0;
            csum_reg  <= '0;
            wl_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            hold_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                S_LEN_HI: begin
                    if (accept) begin
                        len_reg[15:8] <= in_data;
                        csum_reg      <= csum_reg ^ in_data;
                        state_reg     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_reg[7:0] <= in_data;
                        csum_reg     <= csum_reg ^ in_data;
                        // Overflow is caught here, before any memory write.
                        if (len_full > MAX_WORDS) begin
                            state_reg <= S_ERR;
                            err_reg   <= 1'b1;
                        end else if (len_full == 17'd0) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        hi_reg    <= in_data;
                        csum_reg  <= csum_reg ^ in_data;
                        state_reg <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        csum_reg  <= csum_reg ^ in_data;
                        we_reg    <= 1'b1;
                        wdata_reg <= {hi_reg, in_data};
                        addr_reg  <= wl_reg[ADDR_W-1:0];
                        wl_reg    <= wl_reg + 1'b1;
                        // Next state is decided from the post-increment count,
                        // so the strobe cycle already shows where we go next.
                        if (wl_next_full < {1'b0, len_reg}) begin
                            state_reg <= S_DATA_HI;
                        end else begin
                            state_reg <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum_reg) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            hold_reg  <= 1'b0;
                        end else begin
                            state_reg <= S_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg <= S_LEN_HI;
                        done_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                        hold_reg  <= 1'b1;
                        csum_reg  <= '0;
                        wl_reg    <= '0;
                        addr_reg  <= '0;
                        len_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= S_ERR;
                    err_reg   <= 1'b1;
                    hold_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready             = ready_int;
    assign mem_we               = we_reg;
    assign mem_addr             = addr_reg;
    assign mem_wdata            = wdata_reg;
    assign cpu_hold             = hold_reg;
    assign done                 = done_reg;
    assign error                = err_reg;
    assign words_loaded         = wl_reg;
    assign current_state_output = state_reg;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader: good load, empty image, bad checksum with
// re-arm, length overflow, gapped stream and asynchronous reset mid-frame.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              start = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        current_state_output;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    prog_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .start                (start),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .cpu_hold             (cpu_hold),
        .done                 (done),
        .error                (error),
        .words_loaded         (words_loaded),
        .current_state_output (current_state_output)
    );

    always #5 clk = ~clk;

    // One entry per cycle that mem_we is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%0h data=%04h", mem_addr, mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            $display("byte %02h accepted state=%0d", b, current_state_output);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int maxgap);
        foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_good_writes(input string tag);
        logic [15:0] exp_d[3];
        exp_d[0] = 16'h1234;
        exp_d[1] = 16'hABCD;
        exp_d[2] = 16'h00FF;
        chk({tag, "_nwrites"}, 32'(wr_data_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_data"}, 32'(wr_data_q[i]), 32'(exp_d[i]));
        end
    endtask

    task automatic chk_done(input string tag, input int nwords);
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_state"}, 32'(current_state_output), 32'd5);
        chk({tag, "_words"}, 32'(words_loaded), 32'(nwords));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_state"}, 32'(current_state_output), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd1);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    logic [7:0] good_f[$]  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBC};
    logic [7:0] bad_f[$]   = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBD};
    logic [7:0] empty_f[$] = '{8'h00, 8'h00, 8'h00};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(current_state_output), 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;

        // Good load, back-to-back bytes with in_valid held through strobes
        send_frame(good_f, 0);
        chk_done("good", 3);
        chk_good_writes("good");
        chk("good_hold_addr",  32'(mem_addr), 32'd2);
        chk("good_hold_wdata", 32'(mem_wdata), 32'h00FF);

        // start ignored outside DONE/ERR is exercised after re-arm below
        pulse_start("rearm1");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_state", 32'(current_state_output), 32'd0);

        // Empty image
        send_frame(empty_f, 0);
        chk_done("empty", 0);
        chk("empty_nwrites", 32'(wr_data_q.size()), 32'd0);
        pulse_start("rearm2");

        // Bad checksum: writes happen, then ERR
        send_frame(bad_f, 0);
        chk_good_writes("bad");
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_done",  32'(done), 32'd0);
        chk("bad_hold",  32'(cpu_hold), 32'd1);
        chk("bad_state", 32'(current_state_output), 32'd6);
        chk("bad_ready", 32'(in_ready), 32'd0);
        pulse_start("rearm3");
        send_frame(good_f, 0);
        chk_done("after_err", 3);
        chk_good_writes("after_err");
        pulse_start("rearm4");

        // Length overflow: 0x0101 = 257 words > 256
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("ovf_state", 32'(current_state_output), 32'd6);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_hold",  32'(cpu_hold), 32'd1);
        in_data = 8'h12;
        repeat (4) @(negedge clk);
        chk("ovf_ready",   32'(in_ready), 32'd0);
        chk("ovf_state2",  32'(current_state_output), 32'd6);
        chk("ovf_nwrites", 32'(wr_data_q.size()), 32'd0);
        in_valid = 1'b0;
        pulse_start("rearm5");

        // Gapped stream
        send_frame(good_f, 5);
        chk_done("gaps", 3);
        chk_good_writes("gaps");
        pulse_start("rearm6");

        // Asynchronous reset after five bytes
        for (int i = 0; i < 5; i++) send_byte(good_f[i], 0);
        chk("mid_words",   32'(words_loaded), 32'd1);
        chk("mid_nwrites", 32'(wr_data_q.size()), 32'd1);
        chk("mid_state",   32'(current_state_output), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(current_state_output), 32'd0);
        chk("arst_hold",  32'(cpu_hold), 32'd1);
        chk("arst_words", 32'(words_loaded), 32'd0);
        chk("arst_wdata", 32'(mem_wdata), 32'd0);
        chk("arst_we",    32'(mem_we), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_frame(good_f, 0);
        chk_done("post_rst", 3);
        chk_good_writes("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
